// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port SRAM between the instruction-fetch
// port (port 0) and the load/store port (port 1). Grants are combinational
// and an access completes at the posedge where its grant is high. Round-robin
// mode limits a port to MAX_BURST back-to-back grants while the other port
// waits. Fixed-priority mode always favours port 0.
module mem_arbiter #(
    parameter int AW         = 14,
    parameter int DW         = 32,
    parameter int MAX_BURST  = 4,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_wd,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_wd,
    output logic          p0_gnt,
    output logic          p1_gnt,
    output logic          p0_rvalid,
    output logic          p1_rvalid,
    output logic [DW-1:0] p0_rdata,
    output logic [DW-1:0] p1_rdata,
    output logic [AW-1:0] mem_addr,
    output logic          mem_we,
    output logic [DW-1:0] mem_wd,
    input  logic [DW-1:0] mem_rd
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } state_t;

    localparam logic [3:0] MAX_BURST_C = 4'(MAX_BURST);
    localparam logic       FIXED_C     = (FIXED_PRIO != 0);

    // Burst counter increment that sticks at 15 instead of wrapping.
    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'd15) ? 4'd15 : (v + 4'd1);
    endfunction

    state_t          state_r, state_s;
    logic [3:0]      cnt_r, cnt_s;
    logic            ptr_r, ptr_s;
    logic            gnt0_s, gnt1_s;
    logic            p0_rvalid_r, p1_rvalid_r;
    logic [DW-1:0]   p0_rdata_r, p1_rdata_r;

    // Arbitration state, burst counter and priority pointer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
            ptr_r   <= 1'b0;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            ptr_r   <= ptr_s;
        end
    end

    // Next-state, counter and raw grant decision.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        ptr_s   = ptr_r;
        gnt0_s  = 1'b0;
        gnt1_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (p0_req && p1_req) begin
                    // ptr names the port that lost the previous conflict
                    if (FIXED_C || !ptr_r) begin
                        gnt0_s  = 1'b1;
                        state_s = OWN0;
                    end else begin
                        gnt1_s  = 1'b1;
                        state_s = OWN1;
                    end
                    cnt_s = 4'd1;
                end else if (p0_req) begin
                    gnt0_s  = 1'b1;
                    state_s = OWN0;
                    cnt_s   = 4'd1;
                end else if (p1_req) begin
                    gnt1_s  = 1'b1;
                    state_s = OWN1;
                    cnt_s   = 4'd1;
                end else begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end
            end
            OWN0: begin
                if (p0_req && (!p1_req || FIXED_C || (cnt_r < MAX_BURST_C))) begin
                    gnt0_s  = 1'b1;
                    state_s = OWN0;
                    cnt_s   = sat_inc(cnt_r);
                end else if (p1_req) begin
                    gnt1_s  = 1'b1;
                    state_s = OWN1;
                    cnt_s   = 4'd1;
                end else begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end
            end
            OWN1: begin
                if (p1_req && (!p0_req || (!FIXED_C && (cnt_r < MAX_BURST_C)))) begin
                    gnt1_s  = 1'b1;
                    state_s = OWN1;
                    cnt_s   = sat_inc(cnt_r);
                end else if (p0_req) begin
                    gnt0_s  = 1'b1;
                    state_s = OWN0;
                    cnt_s   = 4'd1;
                end else begin
                    state_s = IDLE;
                    cnt_s   = 4'd0;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = 4'd0;
            end
        endcase
        // On a conflict the loser gets the pointer so it wins the next tie.
        if (p0_req && p1_req) begin
            ptr_s = gnt0_s ? 1'b1 : 1'b0;
        end else begin
            ptr_s = ptr_r;
        end
    end

    // Reset kills grants immediately so no SRAM write can slip through.
    assign p0_gnt = gnt0_s & reset;
    assign p1_gnt = gnt1_s & reset;

    // SRAM request mux; idle bus is driven to all zeros.
    always_comb begin
        mem_addr = {AW{1'b0}};
        mem_we   = 1'b0;
        mem_wd   = {DW{1'b0}};
        if (p0_gnt) begin
            mem_addr = p0_addr;
            mem_we   = p0_we;
            mem_wd   = p0_wd;
        end else if (p1_gnt) begin
            mem_addr = p1_addr;
            mem_we   = p1_we;
            mem_wd   = p1_wd;
        end else begin
            mem_addr = {AW{1'b0}};
            mem_we   = 1'b0;
            mem_wd   = {DW{1'b0}};
        end
    end

    // Read-data capture and one-cycle valid pulse per granted read.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            p0_rvalid_r <= 1'b0;
            p1_rvalid_r <= 1'b0;
            p0_rdata_r  <= {DW{1'b0}};
            p1_rdata_r  <= {DW{1'b0}};
        end else begin
            p0_rvalid_r <= p0_gnt & ~p0_we;
            p1_rvalid_r <= p1_gnt & ~p1_we;
            if (p0_gnt && !p0_we) begin
                p0_rdata_r <= mem_rd;
            end
            if (p1_gnt && !p1_we) begin
                p1_rdata_r <= mem_rd;
            end
        end
    end

    assign p0_rvalid = p0_rvalid_r;
    assign p1_rvalid = p1_rvalid_r;
    assign p0_rdata  = p0_rdata_r;
    assign p1_rdata  = p1_rdata_r;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed vectors for mem_arbiter with a behavioural SRAM
// (sync write, async read). A second instance runs in fixed-priority mode.
module tb_mem_arbiter;

    localparam int AW = 14;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          p0_req, p0_we, p1_req, p1_we;
    logic [AW-1:0] p0_addr, p1_addr;
    logic [DW-1:0] p0_wd, p1_wd;
    logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
    logic [DW-1:0] p0_rdata, p1_rdata;
    logic [AW-1:0] mem_addr;
    logic          mem_we;
    logic [DW-1:0] mem_wd, mem_rd;

    logic          fp_reset, fp_p0_req, fp_p1_req;
    logic          fp_p0_gnt, fp_p1_gnt, fp_p0_rvalid, fp_p1_rvalid;
    logic [DW-1:0] fp_p0_rdata, fp_p1_rdata, fp_mem_wd;
    logic [AW-1:0] fp_mem_addr;
    logic          fp_mem_we;

    logic [DW-1:0] sram [0:(1<<AW)-1] = '{default: 32'h0};

    int vec_cnt = 0;
    int err_cnt = 0;

    always #5 clk = ~clk;

    // Behavioural SRAM: written at the clock edge, read combinationally.
    always @(posedge clk) begin
        if (mem_we) sram[mem_addr] <= mem_wd;
    end
    assign mem_rd = sram[mem_addr];

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4), .FIXED_PRIO(0)) dut (
        .clk(clk), .reset(reset),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wd(p0_wd),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wd(p1_wd),
        .p0_gnt(p0_gnt), .p1_gnt(p1_gnt),
        .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
        .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4), .FIXED_PRIO(1)) dut_fp (
        .clk(clk), .reset(fp_reset),
        .p0_req(fp_p0_req), .p0_we(1'b0), .p0_addr(14'h0001), .p0_wd(32'h0),
        .p1_req(fp_p1_req), .p1_we(1'b0), .p1_addr(14'h0002), .p1_wd(32'h0),
        .p0_gnt(fp_p0_gnt), .p1_gnt(fp_p1_gnt),
        .p0_rvalid(fp_p0_rvalid), .p1_rvalid(fp_p1_rvalid),
        .p0_rdata(fp_p0_rdata), .p1_rdata(fp_p1_rdata),
        .mem_addr(fp_mem_addr), .mem_we(fp_mem_we), .mem_wd(fp_mem_wd), .mem_rd(32'h0)
    );

    task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_p0(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        p0_req = req; p0_we = we; p0_addr = addr; p0_wd = wd;
    endtask

    task automatic set_p1(input logic req, input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wd);
        p1_req = req; p1_we = we; p1_addr = addr; p1_wd = wd;
    endtask

    initial begin
        logic [11:0] pat;
        logic [4:0]  pat_rst;
        logic        prev0;
        pat     = 12'b0000_1111_0000;
        pat_rst = 5'b10000;

        // Reset held with both ports requesting; port 1 tries a write.
        reset = 1'b0; fp_reset = 1'b0; fp_p0_req = 1'b0; fp_p1_req = 1'b0;
        set_p0(1'b1, 1'b0, 14'h0000, 32'h0);
        set_p1(1'b1, 1'b1, 14'h0020, 32'hBAD0_BAD0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check_val("rst_gnt0", p0_gnt, 1'b0);
            check_val("rst_gnt1", p1_gnt, 1'b0);
            check_val("rst_we", mem_we, 1'b0);
        end
        check_val("rst_rv0", p0_rvalid, 1'b0);
        check_val("rst_rv1", p1_rvalid, 1'b0);
        check_val("rst_rd0", p0_rdata, 32'h0);
        check_val("rst_rd1", p1_rdata, 32'h0);

        // Release: port 0 wins the first tie from IDLE.
        tick();
        reset = 1'b1;
        set_p1(1'b1, 1'b1, 14'h0010, 32'hDEAD_BEEF);
        #1;
        check_val("rel_gnt0", p0_gnt, 1'b1);
        check_val("rel_gnt1", p1_gnt, 1'b0);
        check_val("rel_we", mem_we, 1'b0);
        check_val("rel_addr", mem_addr, 14'h0000);

        tick();
        set_p0(1'b0, 1'b0, 14'h0000, 32'h0);
        #1;
        check_val("rd0_rv", p0_rvalid, 1'b1);
        check_val("wr1_gnt1", p1_gnt, 1'b1);
        check_val("wr1_gnt0", p0_gnt, 1'b0);
        check_val("wr1_we", mem_we, 1'b1);
        check_val("wr1_addr", mem_addr, 14'h0010);
        check_val("wr1_wd", mem_wd, 32'hDEAD_BEEF);

        tick();
        set_p1(1'b0, 1'b0, 14'h3FFF, 32'hFFFF_FFFF);
        set_p0(1'b1, 1'b0, 14'h0010, 32'h0);
        #1;
        check_val("rd10_gnt0", p0_gnt, 1'b1);
        check_val("rd10_gnt1", p1_gnt, 1'b0);
        check_val("rv0_one_cycle", p0_rvalid, 1'b0);
        check_val("wr_no_rv1", p1_rvalid, 1'b0);
        check_val("rd10_addr", mem_addr, 14'h0010);
        check_val("sram_10", sram[14'h0010], 32'hDEAD_BEEF);

        tick();
        set_p0(1'b0, 1'b0, 14'h2AAA, 32'h0000_1234);
        #1;
        check_val("rd10_rv", p0_rvalid, 1'b1);
        check_val("rd10_data", p0_rdata, 32'hDEAD_BEEF);
        check_val("rd10_rv1", p1_rvalid, 1'b0);
        check_val("idle_gnt0", p0_gnt, 1'b0);
        check_val("idle_gnt1", p1_gnt, 1'b0);
        check_val("idle_we", mem_we, 1'b0);
        check_val("idle_addr", mem_addr, 14'h0000);
        check_val("idle_wd", mem_wd, 32'h0);
        check_val("rst_no_write", sram[14'h0020], 32'h0);

        // Port 1 writes words 0..2, then port 0 reads them back to back.
        tick();
        for (int i = 0; i < 3; i++) begin
            set_p1(1'b1, 1'b1, 14'(i), 32'hC0DE_0000 + 32'(i));
            #1;
            check_val("fill_gnt1", p1_gnt, 1'b1);
            check_val("fill_addr", mem_addr, 14'(i));
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            set_p1(1'b0, 1'b0, 14'h0000, 32'h0);
            set_p0(1'b1, 1'b0, 14'(i), 32'h0);
            #1;
            check_val("b2b_gnt0", p0_gnt, 1'b1);
            check_val("b2b_rv", p0_rvalid, (i > 0));
            if (i > 0) check_val("b2b_data", p0_rdata, 32'hC0DE_0000 + 32'(i - 1));
            tick();
        end
        set_p0(1'b0, 1'b0, 14'h0000, 32'h0);
        #1;
        check_val("b2b_rv_last", p0_rvalid, 1'b1);
        check_val("b2b_data_last", p0_rdata, 32'hC0DE_0002);
        tick();
        check_val("b2b_rv_end", p0_rvalid, 1'b0);

        // Burst limit: port 0 owns, port 1 joins; expect 4/4 alternation.
        tick();
        set_p0(1'b1, 1'b0, 14'h0003, 32'h0);
        set_p1(1'b0, 1'b0, 14'h0004, 32'h0);
        prev0 = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (i == 1) p1_req = 1'b1;
            #1;
            check_val("burst_gnt0", p0_gnt, !pat[i]);
            check_val("burst_gnt1", p1_gnt, pat[i]);
            check_val("burst_addr", mem_addr, pat[i] ? 14'h0004 : 14'h0003);
            check_val("burst_rv0", p0_rvalid, prev0);
            prev0 = !pat[i];
            tick();
        end
        set_p0(1'b0, 1'b0, 14'h0000, 32'h0);
        set_p1(1'b0, 1'b0, 14'h0000, 32'h0);
        tick();

        // Reset lands in the same cycle as a granted port 1 write.
        set_p1(1'b1, 1'b1, 14'h0030, 32'hFEED_FACE);
        #1;
        check_val("pre_rst_gnt1", p1_gnt, 1'b1);
        check_val("pre_rst_we", mem_we, 1'b1);
        #2;
        reset = 1'b0;
        #1;
        check_val("midrst_gnt1", p1_gnt, 1'b0);
        check_val("midrst_we", mem_we, 1'b0);
        tick();
        check_val("midrst_sram", sram[14'h0030], 32'h0);
        tick();
        reset = 1'b1;
        set_p0(1'b1, 1'b0, 14'h0005, 32'h0);
        set_p1(1'b1, 1'b0, 14'h0006, 32'h0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check_val("post_rst_gnt0", p0_gnt, !pat_rst[i]);
            check_val("post_rst_gnt1", p1_gnt, pat_rst[i]);
            tick();
        end
        set_p0(1'b0, 1'b0, 14'h0000, 32'h0);
        set_p1(1'b0, 1'b0, 14'h0000, 32'h0);

        // Fixed priority: port 0 wins every cycle while it requests.
        fp_reset = 1'b1;
        fp_p0_req = 1'b1;
        fp_p1_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            check_val("fp_gnt0", fp_p0_gnt, 1'b1);
            check_val("fp_gnt1", fp_p1_gnt, 1'b0);
            tick();
        end
        fp_p0_req = 1'b0;
        #1;
        check_val("fp_drop_gnt1", fp_p1_gnt, 1'b1);
        check_val("fp_drop_gnt0", fp_p0_gnt, 1'b0);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
